ram_arbiter: RTL and testbench

//  Shares the single-port data RAM between the instruction-fetch requester (if_*)
//  and the load/store requester (d_*). Sequences each access into one RAM strobe

---
 rtl/ram_arbiter.sv | 140 ++++++++++++++
 tb/tb_ram_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - arbitrates fetch and load/store access to the shared single-port data RAM
module ram_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int DEPTH      = 16,
    parameter int MAX_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              read_ram,
    output logic              write_ram,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_write_data,
    input  logic [DATA_W-1:0] ram_out
);
    localparam int SW = $clog2(MAX_STREAK + 1);

    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_own_d;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [SW-1:0]     r_streak;
    logic              r_if_rvalid;
    logic              r_if_err;
    logic [DATA_W-1:0] r_if_rdata;
    logic              r_d_done;
    logic              r_d_err;
    logic [DATA_W-1:0] r_d_rdata;
    logic              w_in_range;
    logic              w_d_win;
    logic              w_if_win;

    assign w_in_range = (r_addr < ADDR_W'(DEPTH));
    // Data side has priority until it has starved a waiting fetch MAX_STREAK times in a row.
    assign w_d_win    = d_req && (!if_req || (r_streak != SW'(MAX_STREAK)));
    assign w_if_win   = if_req && !w_d_win;

    always_comb begin
        w_next    = r_state;
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        read_ram  = 1'b0;
        write_ram = 1'b0;
        case (r_state)
            S_IDLE: begin
                if_gnt = w_if_win;
                d_gnt  = w_d_win;
                if (w_if_win || w_d_win) begin
                    w_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                read_ram  = w_in_range && !r_we;
                write_ram = w_in_range && r_we;
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_own_d     <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_streak    <= '0;
            r_if_rvalid <= 1'b0;
            r_if_err    <= 1'b0;
            r_if_rdata  <= '0;
            r_d_done    <= 1'b0;
            r_d_err     <= 1'b0;
            r_d_rdata   <= '0;
        end else begin
            r_state     <= w_next;
            r_if_rvalid <= 1'b0;
            r_if_err    <= 1'b0;
            r_d_done    <= 1'b0;
            r_d_err     <= 1'b0;
            if (d_gnt) begin
                r_own_d <= 1'b1;
                r_we    <= d_we;
                r_addr  <= d_addr;
                r_wdata <= d_wdata;
                if (!if_req) begin
                    r_streak <= '0;
                end else if (r_streak != SW'(MAX_STREAK)) begin
                    r_streak <= r_streak + 1'b1;
                end
            end else if (if_gnt) begin
                r_own_d  <= 1'b0;
                r_we     <= 1'b0;
                r_addr   <= if_addr;
                r_wdata  <= '0;
                r_streak <= '0;
            end
            if (r_state == S_ACCESS) begin
                if (r_own_d) begin
                    r_d_done <= 1'b1;
                    r_d_err  <= !w_in_range;
                    if (!r_we) begin
                        r_d_rdata <= w_in_range ? ram_out : '0;
                    end
                end else begin
                    r_if_rvalid <= 1'b1;
                    r_if_err    <= !w_in_range;
                    r_if_rdata  <= w_in_range ? ram_out : '0;
                end
            end
        end
    end

    assign ram_addr       = r_addr;
    assign ram_write_data = r_wdata;
    assign if_rvalid      = r_if_rvalid;
    assign if_err         = r_if_err;
    assign if_rdata       = r_if_rdata;
    assign d_done         = r_d_done;
    assign d_err          = r_d_err;
    assign d_rdata        = r_d_rdata;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - scoreboard bench for ram_arbiter
module tb_ram_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_gnt, d_done, d_err;
    logic [31:0] d_rdata;
    logic        read_ram, write_ram;
    logic [31:0] ram_addr, ram_write_data, ram_out;

    logic        preload = 1'b1;
    logic [31:0] ram   [16];
    logic [31:0] model [16];

    typedef struct {
        bit          is_d;
        bit          err;
        bit          chk_rd;
        logic [31:0] rdata;
    } exp_t;
    exp_t q[$];

    int n_vec = 0;
    int n_bad = 0;

    ram_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
        .read_ram(read_ram), .write_ram(write_ram), .ram_addr(ram_addr),
        .ram_write_data(ram_write_data), .ram_out(ram_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) ram[i] <= 32'(i);
        end else if (write_ram) begin
            ram[ram_addr[3:0]] <= ram_write_data;
        end
    end
    assign ram_out = ram[ram_addr[3:0]];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (read_ram && write_ram) chk("both_strobes", 1, 0);
        if (if_rvalid) begin
            if (q.size() == 0) chk("if_spurious", 1, 0);
            else begin
                e = q.pop_front();
                chk("if_owner", 0, {63'd0, e.is_d});
                chk("if_err", {63'd0, if_err}, {63'd0, e.err});
                chk("if_rdata", {32'd0, if_rdata}, {32'd0, e.rdata});
            end
        end
        if (d_done) begin
            if (q.size() == 0) chk("d_spurious", 1, 0);
            else begin
                e = q.pop_front();
                chk("d_owner", 1, {63'd0, e.is_d});
                chk("d_err", {63'd0, d_err}, {63'd0, e.err});
                if (e.chk_rd) chk("d_rdata", {32'd0, d_rdata}, {32'd0, e.rdata});
            end
        end
    end

    function automatic exp_t mk_exp(input bit is_d, input bit we, input logic [31:0] addr);
        exp_t e;
        e.is_d   = is_d;
        e.err    = (addr >= 32'd16);
        e.chk_rd = !we;
        e.rdata  = (addr < 32'd16) ? model[addr[3:0]] : 32'd0;
        return e;
    endfunction

    task automatic access(input bit is_d, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit abort);
        bit inr;
        int k;
        inr = (addr < 32'd16);
        @(negedge clk);
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        #1;
        k = 0;
        while (!(is_d ? d_gnt : if_gnt) && k < 20) begin
            @(negedge clk); #1;
            k++;
        end
        if (k >= 20) begin
            chk("gnt_timeout", 0, 1);
            if_req = 1'b0; d_req = 1'b0;
            return;
        end
        @(posedge clk); #1;
        if (is_d) d_req = 1'b0; else if_req = 1'b0;
        @(negedge clk);
        chk("read_strobe", {63'd0, read_ram}, {63'd0, inr && !we});
        chk("write_strobe", {63'd0, write_ram}, {63'd0, inr && we});
        chk("ram_addr", {32'd0, ram_addr}, {32'd0, addr});
        if (abort) begin
            rst = 1'b1;
            @(posedge clk); #1;
            chk("rst_mid_strobe", {62'd0, read_ram, write_ram}, 0);
            chk("rst_mid_pulse", {62'd0, if_rvalid, d_done}, 0);
            rst = 1'b0;
            return;
        end
        q.push_back(mk_exp(is_d, we, addr));
        if (is_d && we && inr) model[addr[3:0]] = wdata;
    endtask

    initial begin
        bit exp_d [10];
        int k;
        for (int i = 0; i < 16; i++) model[i] = 32'(i);
        repeat (2) @(posedge clk);
        #1;
        preload = 1'b0;
        @(negedge clk);
        chk("rst_strobes", {62'd0, read_ram, write_ram}, 0);
        chk("rst_pulses", {60'd0, if_rvalid, if_err, d_done, d_err}, 0);
        chk("rst_rdata", {if_rdata, d_rdata}, 0);
        chk("rst_ram_bus", {ram_addr, ram_write_data}, 0);
        chk("rst_gnt", {62'd0, if_gnt, d_gnt}, 0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_strobes", {62'd0, read_ram, write_ram, if_gnt, d_gnt} >> 0, 0);
        end

        access(0, 0, 32'd5, 0, 0);
        access(1, 1, 32'd3, 32'hDEAD_BEEF, 0);
        access(1, 0, 32'd3, 0, 0);
        repeat (3) @(negedge clk);

        exp_d = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        if_addr = 32'd2; d_addr = 32'd7; d_we = 1'b0; d_wdata = '0;
        if_req = 1'b1; d_req = 1'b1;
        #1;
        for (int g = 0; g < 10; g++) begin
            k = 0;
            while (!(if_gnt || d_gnt) && k < 20) begin
                @(negedge clk); #1;
                k++;
            end
            if (k >= 20) begin
                chk("fair_timeout", 0, 1);
                break;
            end
            chk("fair_order", {63'd0, d_gnt}, {63'd0, exp_d[g]});
            q.push_back(mk_exp(d_gnt, 0, d_gnt ? 32'd7 : 32'd2));
            @(negedge clk);
            if (g == 9) begin
                if_req = 1'b0; d_req = 1'b0;
            end
            #1;
        end
        repeat (3) @(negedge clk);

        access(1, 1, 32'd16, 32'h1234_5678, 0);
        repeat (2) @(negedge clk);
        chk("oor_ram0", {32'd0, ram[0]}, 0);
        access(0, 0, 32'hFFFF_FFFF, 0, 0);
        repeat (3) @(negedge clk);

        access(0, 0, 32'd9, 0, 1);
        repeat (4) @(negedge clk);
        chk("rst_mid_q", q.size(), 0);
        access(0, 0, 32'd9, 0, 0);
        access(1, 0, 32'd5, 0, 0);
        access(1, 0, 32'd3, 0, 0);
        repeat (4) @(negedge clk);
        chk("q_drain", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
